two_way_cache_ctrl: RTL and testbench

Controller for a two-way set-associative, write-through, no-write-allocate cache between the core's load/store port and a single-word memory port. Holds tag, valid, data and per-set LRU state. Performs lookup, sequences multi-word line refills on read misses, and forwards every store to memory. Victim selection uses one LRU bit per set.

---
 rtl/cache_pkg.sv | 28 ++
 rtl/two_way_cache_way.sv | 49 ++++
 rtl/two_way_cache_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_two_way_cache_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types for the two-way cache controller: FSM state encoding and the
// default-configuration address split.
package cache_pkg;

    localparam int BYTE_OFF_W    = 2;
    localparam int DEF_ADDR_SIZE = 32;
    localparam int DEF_NUM_SETS  = 16;
    localparam int DEF_WORDS     = 4;
    localparam int DEF_WORD_W    = $clog2(DEF_WORDS);
    localparam int DEF_SET_W     = $clog2(DEF_NUM_SETS);
    localparam int DEF_TAG_W     = DEF_ADDR_SIZE - BYTE_OFF_W - DEF_WORD_W - DEF_SET_W;

    typedef struct packed {
        logic [DEF_TAG_W-1:0]  tag;
        logic [DEF_SET_W-1:0]  set_idx;
        logic [DEF_WORD_W-1:0] word_idx;
        logic [BYTE_OFF_W-1:0] byte_off;
    } addr_split_t;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        REFILL,
        RESPOND,
        WRITE
    } state_t;

endpackage

// File: rtl/two_way_cache_way.sv
// One way of the cache: tag, valid and data storage with combinational read
// and synchronous word / tag writes. Only the valid bits are reset.
module two_way_cache_way #(
    parameter int NUM_SETS        = 16,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int TAG_W           = 24,
    parameter int SET_W           = $clog2(NUM_SETS),
    parameter int WORD_W          = $clog2(WORDS_PER_BLOCK)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SET_W-1:0]  set_idx,
    input  logic [WORD_W-1:0] rd_word,
    output logic [31:0]       rd_data,
    output logic [TAG_W-1:0]  rd_tag,
    output logic              rd_valid,
    input  logic              word_we,
    input  logic [WORD_W-1:0] wr_word,
    input  logic [31:0]       wr_data,
    input  logic              tag_we,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic              inv_we
);

    logic [31:0]         data_mem [NUM_SETS][WORDS_PER_BLOCK];
    logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
    logic [NUM_SETS-1:0] valid_q, valid_d;

    assign rd_data  = data_mem[set_idx][rd_word];
    assign rd_tag   = tag_mem[set_idx];
    assign rd_valid = valid_q[set_idx];

    always_comb begin
        valid_d = valid_q;
        if (inv_we) valid_d[set_idx] = 1'b0;
        if (tag_we) valid_d[set_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) valid_q <= '0;
        else     valid_q <= valid_d;
    end

    always_ff @(posedge clk) begin
        if (word_we) data_mem[set_idx][wr_word] <= wr_data;
        if (tag_we)  tag_mem[set_idx]           <= wr_tag;
    end

endmodule

// File: rtl/two_way_cache_ctrl.sv
// Two-way set-associative, write-through, no-write-allocate cache controller
// with per-set LRU bit and multi-word line refill over a single-word port.
module two_way_cache_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_SIZE       = 32,
    parameter int NUM_SETS        = 16,
    parameter int WORDS_PER_BLOCK = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [ADDR_SIZE-1:0] cpu_addr,
    input  logic [31:0]          cpu_wdata,
    output logic                 cpu_ready,
    output logic [31:0]          cpu_rdata,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic                 mem_ready,
    input  logic [31:0]          mem_rdata
);

    localparam int WORD_W  = $clog2(WORDS_PER_BLOCK);
    localparam int SET_W   = $clog2(NUM_SETS);
    localparam int WADDR_W = ADDR_SIZE - BYTE_OFF_W;
    localparam int TAG_W   = WADDR_W - WORD_W - SET_W;

    state_t              state_q, state_d;
    logic [WADDR_W-1:0]  waddr_q, waddr_d;
    logic                we_q, we_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [WORD_W-1:0]   cnt_q, cnt_d;
    logic                victim_q, victim_d;
    logic [NUM_SETS-1:0] lru_q, lru_d;

    logic [TAG_W-1:0]  tag_f;
    logic [SET_W-1:0]  set_f;
    logic [WORD_W-1:0] word_f;
    logic [1:0]        unused_byte_off;

    logic [31:0]       way_rdata [2];
    logic [TAG_W-1:0]  way_tag   [2];
    logic [1:0]        way_valid, word_we, tag_we, inv_we;
    logic [WORD_W-1:0] wr_word;
    logic [31:0]       wr_data;
    logic              hit0, hit1, hit, hit_way, victim_sel;

    assign {tag_f, set_f, word_f} = waddr_q;
    assign unused_byte_off        = cpu_addr[BYTE_OFF_W-1:0];

    for (genvar g = 0; g < 2; g++) begin : g_way
        two_way_cache_way #(
            .NUM_SETS       (NUM_SETS),
            .WORDS_PER_BLOCK(WORDS_PER_BLOCK),
            .TAG_W          (TAG_W),
            .SET_W          (SET_W),
            .WORD_W         (WORD_W)
        ) u_way (
            .clk     (clk),
            .rst     (rst),
            .set_idx (set_f),
            .rd_word (word_f),
            .rd_data (way_rdata[g]),
            .rd_tag  (way_tag[g]),
            .rd_valid(way_valid[g]),
            .word_we (word_we[g]),
            .wr_word (wr_word),
            .wr_data (wr_data),
            .tag_we  (tag_we[g]),
            .wr_tag  (tag_f),
            .inv_we  (inv_we[g])
        );
    end

    // Way 0 has priority should both ways ever match.
    assign hit0       = way_valid[0] && (way_tag[0] == tag_f);
    assign hit1       = way_valid[1] && (way_tag[1] == tag_f) && !hit0;
    assign hit        = hit0 || hit1;
    assign hit_way    = hit1;
    assign victim_sel = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru_q[set_f]);

    always_comb begin
        state_d   = state_q;
        waddr_d   = waddr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        victim_d  = victim_q;
        lru_d     = lru_q;
        word_we   = '0;
        tag_we    = '0;
        inv_we    = '0;
        wr_word   = word_f;
        wr_data   = wdata_q;
        cpu_ready = 1'b0;
        cpu_rdata = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    waddr_d = cpu_addr[ADDR_SIZE-1:BYTE_OFF_W];
                    we_d    = cpu_we;
                    wdata_d = cpu_wdata;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (we_q) begin
                    // Write-through: update a hit line, never allocate on miss.
                    if (hit) begin
                        word_we[hit_way] = 1'b1;
                        lru_d[set_f]     = ~hit_way;
                    end
                    state_d = WRITE;
                end else if (hit) begin
                    cpu_ready    = 1'b1;
                    cpu_rdata    = way_rdata[hit_way];
                    lru_d[set_f] = ~hit_way;
                    state_d      = IDLE;
                end else begin
                    victim_d           = victim_sel;
                    inv_we[victim_sel] = 1'b1;
                    cnt_d              = '0;
                    state_d            = REFILL;
                end
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {tag_f, set_f, cnt_q, 2'b00};
                if (mem_ready) begin
                    word_we[victim_q] = 1'b1;
                    wr_word           = cnt_q;
                    wr_data           = mem_rdata;
                    cnt_d             = cnt_q + 1'b1;
                    if (&cnt_q) begin
                        tag_we[victim_q] = 1'b1;
                        lru_d[set_f]     = ~victim_q;
                        state_d          = RESPOND;
                    end
                end
            end
            RESPOND: begin
                cpu_ready = 1'b1;
                cpu_rdata = way_rdata[victim_q];
                state_d   = IDLE;
            end
            WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {waddr_q, 2'b00};
                mem_wdata = wdata_q;
                if (mem_ready) begin
                    cpu_ready = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lru_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lru_q   <= lru_d;
        end
    end

    always_ff @(posedge clk) begin
        waddr_q  <= waddr_d;
        we_q     <= we_d;
        wdata_q  <= wdata_d;
        victim_q <= victim_d;
    end

endmodule

// File: tb/tb_two_way_cache_ctrl.sv
// Bench for two_way_cache_ctrl: directed scenarios followed by random traffic,
// checked against a behavioural cache/memory model.
module tb_two_way_cache_ctrl;

    localparam int ADDR_SIZE = 32;
    localparam int NUM_SETS  = 16;
    localparam int WPB       = 4;
    localparam int SET_SH    = 2 + $clog2(WPB);
    localparam int TAG_SH    = SET_SH + $clog2(NUM_SETS);

    logic        clk = 1'b0;
    logic        rst, cpu_req, cpu_we, cpu_ready, mem_req, mem_we, mem_ready;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    two_way_cache_ctrl #(.ADDR_SIZE(ADDR_SIZE), .NUM_SETS(NUM_SETS), .WORDS_PER_BLOCK(WPB)) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] bmem [int unsigned];
    bit          mv   [NUM_SETS][2];
    int unsigned mt   [NUM_SETS][2];
    int          mru  [NUM_SETS];
    bit          prev_held = 1'b0;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (bmem.exists(a)) return bmem[a];
        return init_val(a);
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < NUM_SETS; s++) begin
            mv[s][0] = 1'b0; mv[s][1] = 1'b0; mru[s] = 1;
        end
    endfunction

    function automatic int model_find(input logic [31:0] a);
        int s = int'((a >> SET_SH) % NUM_SETS);
        int unsigned t = a >> TAG_SH;
        if (mv[s][0] && mt[s][0] == t) return 0;
        if (mv[s][1] && mt[s][1] == t) return 1;
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; cpu_req = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
        @(posedge clk); @(negedge clk); #1;
        check("rst_cpu_ready", 32'(cpu_ready), 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        rst = 1'b0;
        model_reset();
        prev_held = 1'b0;
    endtask

    // One CPU transaction; called and returns at a falling edge (+#1).
    task automatic run_txn(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                           input int lat, input bit hold, output int lat_obs,
                           output logic [31:0] rd_obs);
        logic [31:0] wa, lb, held, ed;
        logic [31:0] q_addr [$];
        logic [31:0] q_data [$];
        bit          q_we [$];
        int s, w, exp_cyc, c, wait_n, victim;
        bit done;
        wa = {addr[31:2], 2'b00};
        lb = wa & ~32'((WPB * 4) - 1);
        s  = int'((wa >> SET_SH) % NUM_SETS);
        w  = model_find(wa);
        exp_cyc = prev_held ? 1 : 0;
        if (we) begin
            exp_cyc += 1 + lat;
            q_addr.push_back(wa); q_we.push_back(1'b1); q_data.push_back(wd);
        end else if (w >= 0) begin
            exp_cyc += 1;
        end else begin
            exp_cyc += 2 + WPB * lat;
            for (int i = 0; i < WPB; i++) begin
                q_addr.push_back(lb + 32'(4 * i)); q_we.push_back(1'b0); q_data.push_back('0);
            end
        end
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        c = 0; wait_n = 0; done = 1'b0; held = '0;
        while (!done && c < 300) begin
            @(posedge clk); @(negedge clk); c++;
            mem_ready = 1'b0; mem_rdata = '0;
            if (mem_req) begin
                if (wait_n > 0) check("mem_addr_stable", mem_addr, held);
                held = mem_addr;
                wait_n++;
                if (wait_n == lat) begin
                    wait_n = 0;
                    if (q_addr.size() == 0) begin
                        check("mem_extra_op", mem_addr, 32'hFFFF_FFFF);
                    end else begin
                        check("mem_addr", mem_addr, q_addr.pop_front());
                        check("mem_we", 32'(mem_we), 32'(q_we.pop_front()));
                        ed = q_data.pop_front();
                        if (mem_we) check("mem_wdata", mem_wdata, ed);
                    end
                    if (mem_we) bmem[mem_addr] = mem_wdata;
                    else        mem_rdata = mem_rd(mem_addr);
                    mem_ready = 1'b1;
                end
            end
            #1;
            if (cpu_ready) done = 1'b1;
        end
        check("cpu_ready_seen", 32'(done), 1);
        check("latency", 32'(c), 32'(exp_cyc));
        check("mem_ops_left", 32'(q_addr.size()), 0);
        lat_obs = c;
        rd_obs  = cpu_rdata;
        if (!we) check("cpu_rdata", cpu_rdata, mem_rd(wa));
        // Model update: LRU points away from the most recently used way.
        if (w >= 0) begin
            mru[s] = w;
        end else if (!we) begin
            victim = !mv[s][0] ? 0 : (!mv[s][1] ? 1 : 1 - mru[s]);
            mv[s][victim] = 1'b1; mt[s][victim] = wa >> TAG_SH; mru[s] = victim;
        end
        if (hold) begin
            prev_held = 1'b1;
        end else begin
            prev_held = 1'b0;
            cpu_req = 1'b0;
            @(posedge clk); @(negedge clk);
            mem_ready = 1'b0; #1;
            check("idle_cpu_ready", 32'(cpu_ready), 0);
            check("idle_mem_req", 32'(mem_req), 0);
        end
    endtask

    initial begin
        int          lo;
        logic [31:0] rd, a;
        bit          h, wr;
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        @(negedge clk);
        do_reset();

        // Cold read, hit, store hit, store miss
        run_txn(1'b0, 32'h100, 0, 1, 1'b0, lo, rd);
        check("cold_read_latency", 32'(lo), 6);
        check("cold_read_data", rd, init_val(32'h100));
        run_txn(1'b0, 32'h104, 0, 1, 1'b0, lo, rd);
        check("hit_latency", 32'(lo), 1);
        run_txn(1'b1, 32'h104, 32'hDEAD_BEEF, 1, 1'b0, lo, rd);
        check("store_latency", 32'(lo), 2);
        run_txn(1'b0, 32'h104, 0, 1, 1'b0, lo, rd);
        check("store_hit_latency", 32'(lo), 1);
        check("store_hit_data", rd, 32'hDEAD_BEEF);
        run_txn(1'b1, 32'h200, 32'h1234_5678, 1, 1'b0, lo, rd);
        run_txn(1'b0, 32'h200, 0, 1, 1'b0, lo, rd);
        check("store_miss_no_alloc", 32'(lo), 6);
        check("store_miss_data", rd, 32'h1234_5678);

        // LRU eviction: A,B,A,C evicts B
        do_reset();
        run_txn(1'b0, 32'h000, 0, 1, 1'b0, lo, rd);
        run_txn(1'b0, 32'h400, 0, 1, 1'b0, lo, rd);
        run_txn(1'b0, 32'h000, 0, 1, 1'b0, lo, rd);
        check("lru_a_hit", 32'(lo), 1);
        run_txn(1'b0, 32'h800, 0, 1, 1'b0, lo, rd);
        check("lru_c_miss", 32'(lo), 6);
        run_txn(1'b0, 32'h004, 0, 1, 1'b0, lo, rd);
        check("lru_a_kept", 32'(lo), 1);
        run_txn(1'b0, 32'h400, 0, 1, 1'b0, lo, rd);
        check("lru_b_evicted", 32'(lo), 6);

        // Slow memory, then reset in the middle of a refill
        run_txn(1'b0, 32'h308, 0, 3, 1'b0, lo, rd);
        check("slow_refill_latency", 32'(lo), 14);
        run_txn(1'b1, 32'h30C, 32'hCAFE_F00D, 3, 1'b0, lo, rd);
        check("slow_store_latency", 32'(lo), 4);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hA40;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk); #1;
        check("mr_mem_req", 32'(mem_req), 1);
        check("mr_addr0", mem_addr, 32'hA40);
        @(posedge clk); @(negedge clk); #1;
        check("mr_addr0_wait", mem_addr, 32'hA40);
        mem_ready = 1'b1; mem_rdata = mem_rd(32'hA40);
        @(posedge clk); @(negedge clk);
        mem_ready = 1'b0; #1;
        check("mr_addr1", mem_addr, 32'hA44);
        do_reset();
        run_txn(1'b0, 32'hA40, 0, 3, 1'b0, lo, rd);
        check("mr_line_invalid", 32'(lo), 14);
        run_txn(1'b0, 32'h100, 0, 1, 1'b0, lo, rd);
        check("reset_clears_lines", 32'(lo), 6);

        // Back-to-back held requests
        run_txn(1'b0, 32'hA44, 0, 1, 1'b1, lo, rd);
        check("b2b_first", 32'(lo), 1);
        run_txn(1'b0, 32'hA48, 0, 1, 1'b1, lo, rd);
        check("b2b_second", 32'(lo), 2);
        run_txn(1'b0, 32'hA4C, 0, 1, 1'b0, lo, rd);
        check("b2b_third", 32'(lo), 2);

        // Random traffic over a few sets and tags
        for (int n = 0; n < 120; n++) begin
            a  = (32'($urandom_range(0, 3)) << TAG_SH) | (32'($urandom_range(0, 3)) << SET_SH)
               | (32'($urandom_range(0, WPB - 1)) << 2) | 32'($urandom_range(0, 3));
            wr = ($urandom_range(0, 3) == 0);
            h  = (n != 119) && ($urandom_range(0, 3) == 0);
            run_txn(wr, a, $urandom, int'($urandom_range(1, 3)), h, lo, rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
